controlador_puerta: RTL and testbench
=====================================

Name: controlador_puerta

Overview:
- Door controller FSM for one elevator cabin.
- Consumes the 1 Hz square wave from the timer/divider and drives that divider's startTimer/restart inputs.
- Sequences the door through open, dwell, close and reversal.
- Reports door-closed interlock and dwell-expiry to the elevator main controller. The main controller must not move the cabin unless puertaCerrada=1.

Parameters:
- OPEN_S, 10, dwell time with door fully open, in seconds (rising edges of C_1Hz); legal 1..255.
- MOVE_S, 2, door travel time (open or close), in seconds; legal 1..255.
- CNT_W, 8, width of the internal seconds counter; must hold max(OPEN_S, MOVE_S).

Ports:
- C_100Mhz  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous, active-low reset
- C_1Hz  input  1  square wave from the timer/divider; only rising edges are used
- openReq  input  1  level; open request (cabin stopped at floor, or hall/cabin open button)
- closeReq  input  1  level; close-door button
- obstaculo  input  1  level; door-edge obstruction sensor, 1 = blocked
- startTimer  output  1  enable to the divider; 1 in every state except CERRADA
- restart  output  1  one-cycle pulse to the divider on every state entry that restarts timing
- motorAbrir  output  1  drive door motor open
- motorCerrar  output  1  drive door motor closed
- puertaCerrada  output  1  interlock, 1 only in CERRADA
- timeExpired  output  1  one-cycle pulse when the ABIERTA dwell reaches OPEN_S

Behaviour:
- One clock (C_100Mhz). Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state=CERRADA, cnt=0, startTimer=0, restart=0, motorAbrir=0, motorCerrar=0, puertaCerrada=1, timeExpired=0.
- Reset asserted mid-operation aborts immediately to the reset values; no pending request is retained.
- Tick generation:
  - C_1Hz passes through a 2-flop synchronizer, then a rising-edge detector, giving a 1-cycle internal tick.
  - Tick latency is 3 clocks after the C_1Hz rising edge.
  - Ticks are ignored in CERRADA.
- cnt: seconds elapsed in the current state.
  - Cleared on every state entry.
  - Increments by 1 per tick and saturates at 2^CNT_W-1.
- restart:
  - Pulses high for exactly 1 cycle, in the cycle after any transition into ABRIENDO, ABIERTA or CERRANDO.
  - Also pulses on a dwell restart in ABIERTA.
- CERRADA:
  - Motors off; puertaCerrada=1; startTimer=0.
  - openReq=1 -> ABRIENDO. closeReq is ignored.
- ABRIENDO:
  - motorAbrir=1; puertaCerrada=0.
  - cnt==MOVE_S -> ABIERTA.
  - All requests are ignored while opening.
- ABIERTA:
  - Both motors off.
  - obstaculo=1 or openReq=1 holds cnt at 0 and issues restart once per rising edge of the combined hold condition.
  - Else closeReq=1 -> CERRANDO (early close, no timeExpired).
  - Else cnt==OPEN_S -> CERRANDO, with timeExpired=1 for that one cycle.
  - Priority: obstaculo/openReq > closeReq > expiry.
- CERRANDO:
  - motorCerrar=1.
  - obstaculo=1 or openReq=1 -> reversal.
    - If cnt==0, go straight to ABIERTA (dwell restarted).
    - Else go to ABRIENDO with cnt preloaded to MOVE_S-cnt, so the reopen takes the same time as the partial close.
    - Reversal beats completion in the same cycle.
  - cnt==MOVE_S (with no reversal) -> CERRADA; startTimer drops in the same registered update.
- Simultaneous tick and transition: the transition uses the pre-tick cnt, and the tick is discarded.
- motorAbrir and motorCerrar are never both 1, in any cycle, including during reset.

Test Plan:
- Reset check: assert rst_n=0 mid-ABRIENDO -> all outputs return to reset values asynchronously (puertaCerrada=1, motors 0), with no clock edge needed.
- Nominal cycle (OPEN_S=10, MOVE_S=2, fast C_1Hz in sim): one openReq pulse in CERRADA produces:
  - ABRIENDO for 2 ticks, then ABIERTA;
  - timeExpired pulses exactly once after 10 ticks;
  - CERRANDO for 2 ticks, then CERRADA with startTimer=0;
  - restart pulses exactly 3 times.
- Early close: closeReq asserted after 4 ticks in ABIERTA -> CERRANDO next cycle, no timeExpired.
- Obstruction in ABIERTA: obstaculo held for 15 ticks, then released -> no expiry while held; timeExpired comes 10 ticks after release.
- Reversal: obstaculo asserted after 1 tick in CERRANDO -> ABRIENDO, reaching ABIERTA after 1 tick. Obstaculo asserted at cnt==0 in CERRANDO -> ABIERTA directly.
- Priority: closeReq and obstaculo asserted together in ABIERTA -> stays ABIERTA, cnt=0. Tick coinciding with obstaculo at cnt==1 in CERRANDO -> reversal with preload MOVE_S-1=1. Assertion throughout: motorAbrir and motorCerrar are never both 1, and puertaCerrada=1 iff state is CERRADA.

Source files
------------

// File: rtl/controlador_puerta_if.sv
// controlador_puerta_if
// Groups the door controller's divider, request and status signals so the
// controller and its environment share one bundle.
//   C_1Hz         - square wave from the timer/divider (only rising edges matter)
//   openReq       - level, open request (stopped at floor or open button)
//   closeReq      - level, close-door button
//   obstaculo     - level, door-edge obstruction sensor, 1 = blocked
//   startTimer    - divider enable, 1 in every state except CERRADA
//   restart       - one-cycle pulse restarting the divider's timing
//   motorAbrir    - drive door motor open
//   motorCerrar   - drive door motor closed
//   puertaCerrada - door-closed interlock, 1 only in CERRADA
//   timeExpired   - one-cycle pulse when the open dwell runs out
// Modport master is the environment side; slave is the controller itself.
interface controlador_puerta_if;
  logic C_1Hz;
  logic openReq;
  logic closeReq;
  logic obstaculo;
  logic startTimer;
  logic restart;
  logic motorAbrir;
  logic motorCerrar;
  logic puertaCerrada;
  logic timeExpired;

  modport master (
    output C_1Hz, openReq, closeReq, obstaculo,
    input  startTimer, restart, motorAbrir, motorCerrar, puertaCerrada, timeExpired
  );

  modport slave (
    input  C_1Hz, openReq, closeReq, obstaculo,
    output startTimer, restart, motorAbrir, motorCerrar, puertaCerrada, timeExpired
  );
endinterface

// File: rtl/controlador_puerta.sv
// controlador_puerta
// Door controller for one elevator cabin. It sequences the door through
// closed, opening, open dwell, closing and reversal on obstruction. Time is
// measured in seconds from the 1 Hz square wave of the timer/divider, which
// this block enables (startTimer) and re-phases (restart) on each new timed
// interval.
// Ports:
//   C_100Mhz - system clock
//   rst_n    - asynchronous active-low reset
//   bus      - controlador_puerta_if.slave: C_1Hz, openReq, closeReq,
//              obstaculo in; startTimer, restart, motorAbrir, motorCerrar,
//              puertaCerrada, timeExpired out (all outputs registered)
// Parameters:
//   OPEN_S - open dwell in seconds (1..255)
//   MOVE_S - door travel time in seconds (1..255)
//   CNT_W  - seconds counter width, must hold max(OPEN_S, MOVE_S)
module controlador_puerta #(
  parameter int OPEN_S = 10,
  parameter int MOVE_S = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 C_100Mhz,
  input  logic                 rst_n,
  controlador_puerta_if.slave  bus
);

  typedef enum logic [1:0] {
    CERRADA  = 2'd0,
    ABRIENDO = 2'd1,
    ABIERTA  = 2'd2,
    CERRANDO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_C  = CNT_W'(OPEN_S);
  localparam logic [CNT_W-1:0] MOVE_C  = CNT_W'(MOVE_S);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sync_q;
  logic       sync_prev_q;
  logic       tick_q;
  logic       hold_prev_q;

  logic start_timer_q, start_timer_d;
  logic restart_q, restart_d;
  logic motor_abrir_q, motor_abrir_d;
  logic motor_cerrar_q, motor_cerrar_d;
  logic puerta_cerrada_q, puerta_cerrada_d;
  logic time_expired_q, time_expired_d;

  logic             hold;
  logic [CNT_W-1:0] cnt_inc;

  // The 1 Hz input is asynchronous to C_100Mhz: two flops resynchronise it,
  // and a registered rising-edge detector turns each second into a single
  // tick, visible 3 clocks after the C_1Hz rising edge.
  always_ff @(posedge C_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b00;
      sync_prev_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.C_1Hz};
      sync_prev_q <= sync_q[1];
      tick_q      <= sync_q[1] & ~sync_prev_q;
    end
  end

  // Anything that keeps the door open (a blocked edge or a fresh open
  // request) counts as a hold.
  assign hold    = bus.obstaculo | bus.openReq;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // State, seconds counter and all outputs are registered together. The
  // previous hold level is tracked in every state, so a hold that began while
  // closing and caused the reversal into ABIERTA does not produce a second
  // restart once the door is open.
  always_ff @(posedge C_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= CERRADA;
      cnt_q            <= '0;
      hold_prev_q      <= 1'b0;
      start_timer_q    <= 1'b0;
      restart_q        <= 1'b0;
      motor_abrir_q    <= 1'b0;
      motor_cerrar_q   <= 1'b0;
      puerta_cerrada_q <= 1'b1;
      time_expired_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      hold_prev_q      <= hold;
      start_timer_q    <= start_timer_d;
      restart_q        <= restart_d;
      motor_abrir_q    <= motor_abrir_d;
      motor_cerrar_q   <= motor_cerrar_d;
      puerta_cerrada_q <= puerta_cerrada_d;
      time_expired_q   <= time_expired_d;
    end
  end

  // Next-state logic. By default the state holds and cnt advances on a tick.
  // Any transition decides on the pre-tick cnt and overwrites cnt_d, which
  // discards a tick that lands in the same cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = tick_q ? cnt_inc : cnt_q;
    restart_d      = 1'b0;
    time_expired_d = 1'b0;

    case (state_q)
      CERRADA: begin
        // The divider is stopped here, so ticks are ignored.
        cnt_d = '0;
        if (bus.openReq) begin
          state_d   = ABRIENDO;
          restart_d = 1'b1;
        end
      end

      ABRIENDO: begin
        if (cnt_q == MOVE_C) begin
          state_d   = ABIERTA;
          cnt_d     = '0;
          restart_d = 1'b1;
        end
      end

      ABIERTA: begin
        if (hold) begin
          // Dwell is held at zero. The divider is re-phased only when the
          // hold first appears, not on every cycle it stays asserted.
          cnt_d     = '0;
          restart_d = ~hold_prev_q;
        end else if (bus.closeReq) begin
          state_d   = CERRANDO;
          cnt_d     = '0;
          restart_d = 1'b1;
        end else if (cnt_q == OPEN_C) begin
          state_d        = CERRANDO;
          cnt_d          = '0;
          restart_d      = 1'b1;
          time_expired_d = 1'b1;
        end
      end

      CERRANDO: begin
        if (hold) begin
          restart_d = 1'b1;
          if (cnt_q == '0) begin
            // The door has not moved yet, so it is still fully open.
            state_d = ABIERTA;
            cnt_d   = '0;
          end else begin
            // Reopening from a partial close takes as long as the partial
            // close did; starting the open count at MOVE_S-cnt reaches
            // MOVE_S after exactly cnt more seconds.
            state_d = ABRIENDO;
            cnt_d   = MOVE_C - cnt_q;
          end
        end else if (cnt_q == MOVE_C) begin
          state_d = CERRADA;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they change in the same
  // registered update as the state. Each motor is tied to exactly one state,
  // so both motors can never be driven at once.
  always_comb begin
    start_timer_d    = (state_d != CERRADA);
    motor_abrir_d    = (state_d == ABRIENDO);
    motor_cerrar_d   = (state_d == CERRANDO);
    puerta_cerrada_d = (state_d == CERRADA);
  end

  assign bus.startTimer    = start_timer_q;
  assign bus.restart       = restart_q;
  assign bus.motorAbrir    = motor_abrir_q;
  assign bus.motorCerrar   = motor_cerrar_q;
  assign bus.puertaCerrada = puerta_cerrada_q;
  assign bus.timeExpired   = time_expired_q;

endmodule

// File: tb/tb_controlador_puerta.sv
// tb_controlador_puerta
// Directed bench for controlador_puerta with OPEN_S=10, MOVE_S=2. A simulated
// second is 4 clocks of C_1Hz high followed by 4 low, long enough for the
// tick and any resulting transition to settle. Expected output patterns are
// queued when a step is driven and popped when the DUT response is sampled.
module tb_controlador_puerta;

  logic C_100Mhz;
  logic rst_n;

  controlador_puerta_if bus ();

  controlador_puerta #(
    .OPEN_S (10),
    .MOVE_S (2),
    .CNT_W  (8)
  ) dut (
    .C_100Mhz (C_100Mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  // 100 MHz clock.
  initial C_100Mhz = 1'b0;
  always #5 C_100Mhz = ~C_100Mhz;

  // Output patterns: {startTimer, motorAbrir, motorCerrar, puertaCerrada}.
  localparam logic [3:0] P_CLOSED  = 4'b0001;
  localparam logic [3:0] P_OPENING = 4'b1100;
  localparam logic [3:0] P_OPEN    = 4'b1000;
  localparam logic [3:0] P_CLOSING = 4'b1010;

  typedef struct {
    string      tag;
    logic [5:0] outs;
  } exp_t;

  exp_t sb[$];

  int checks      = 0;
  int errors      = 0;
  int restart_cnt = 0;
  int expired_cnt = 0;
  int mon_errors  = 0;
  bit mon_en      = 1'b0;

  // Counts restart/timeExpired pulses and watches the motor and interlock
  // invariants on every cycle once reset has been applied.
  always @(negedge C_100Mhz) begin
    if (mon_en) begin
      if (bus.restart === 1'b1) restart_cnt++;
      if (bus.timeExpired === 1'b1) expired_cnt++;
      assert (!(bus.motorAbrir === 1'b1 && bus.motorCerrar === 1'b1) &&
              (bus.puertaCerrada === !bus.startTimer))
      else begin
        mon_errors++;
        $error("[TB] FAIL invariant observed motorAbrir=%b motorCerrar=%b puertaCerrada=%b startTimer=%b",
               bus.motorAbrir, bus.motorCerrar, bus.puertaCerrada, bus.startTimer);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge C_100Mhz);
  endtask

  task automatic secTick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.C_1Hz = 1'b1;
      cyc(4);
      bus.C_1Hz = 1'b0;
      cyc(4);
    end
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs;
    e   = sb.pop_front();
    obs = {bus.startTimer, bus.motorAbrir, bus.motorCerrar, bus.puertaCerrada,
           bus.restart, bus.timeExpired};
    checks++;
    assert (obs === e.outs)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.outs);
    end
  endtask

  // Queue an expected pattern and compare it against the outputs right now.
  task automatic expectState(input string tag, input logic [3:0] p,
                             input logic rs, input logic te);
    exp_t e;
    e.tag  = tag;
    e.outs = {p, rs, te};
    sb.push_back(e);
    checkOutput();
  endtask

  // Drive request levels, queue the response expected one clock later, and
  // compare it when that clock has passed.
  task automatic applyStimulus(input string tag, input logic o, input logic c,
                               input logic ob, input logic [3:0] p,
                               input logic rs, input logic te);
    exp_t e;
    bus.openReq   = o;
    bus.closeReq  = c;
    bus.obstaculo = ob;
    e.tag  = tag;
    e.outs = {p, rs, te};
    sb.push_back(e);
    cyc(1);
    checkOutput();
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  int rs0;
  int te0;

  initial begin
    rst_n         = 1'b0;
    bus.C_1Hz     = 1'b0;
    bus.openReq   = 1'b0;
    bus.closeReq  = 1'b0;
    bus.obstaculo = 1'b0;
    cyc(3);
    expectState("reset_values", P_CLOSED, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    mon_en = 1'b1;

    // Ticks while closed change nothing.
    secTick(2);
    expectState("idle_ticks_ignored", P_CLOSED, 1'b0, 1'b0);

    // Nominal open / dwell / close cycle.
    rs0 = restart_cnt;
    te0 = expired_cnt;
    applyStimulus("nom_open", 1'b1, 1'b0, 1'b0, P_OPENING, 1'b1, 1'b0);
    applyStimulus("nom_open_release", 1'b0, 1'b0, 1'b0, P_OPENING, 1'b0, 1'b0);
    secTick(1);
    expectState("nom_opening_1s", P_OPENING, 1'b0, 1'b0);
    secTick(1);
    expectState("nom_open", P_OPEN, 1'b0, 1'b0);
    secTick(9);
    expectState("nom_dwell_9s", P_OPEN, 1'b0, 1'b0);
    checkCount("nom_no_early_expiry", expired_cnt - te0, 0);
    secTick(1);
    expectState("nom_closing", P_CLOSING, 1'b0, 1'b0);
    checkCount("nom_expired_once", expired_cnt - te0, 1);
    secTick(1);
    expectState("nom_closing_1s", P_CLOSING, 1'b0, 1'b0);
    secTick(1);
    expectState("nom_closed", P_CLOSED, 1'b0, 1'b0);
    checkCount("nom_restart_count", restart_cnt - rs0, 3);

    // Early close after 4 s of dwell.
    te0 = expired_cnt;
    applyStimulus("ec_open", 1'b1, 1'b0, 1'b0, P_OPENING, 1'b1, 1'b0);
    applyStimulus("ec_open_release", 1'b0, 1'b0, 1'b0, P_OPENING, 1'b0, 1'b0);
    secTick(2);
    expectState("ec_open_reached", P_OPEN, 1'b0, 1'b0);
    secTick(4);
    applyStimulus("ec_close_req", 1'b0, 1'b1, 1'b0, P_CLOSING, 1'b1, 1'b0);
    applyStimulus("ec_close_release", 1'b0, 1'b0, 1'b0, P_CLOSING, 1'b0, 1'b0);
    checkCount("ec_no_expiry", expired_cnt - te0, 0);
    secTick(2);
    expectState("ec_closed", P_CLOSED, 1'b0, 1'b0);

    // Obstruction held for 15 s in ABIERTA.
    applyStimulus("obs_open", 1'b1, 1'b0, 1'b0, P_OPENING, 1'b1, 1'b0);
    applyStimulus("obs_open_release", 1'b0, 1'b0, 1'b0, P_OPENING, 1'b0, 1'b0);
    secTick(2);
    expectState("obs_open_reached", P_OPEN, 1'b0, 1'b0);
    rs0 = restart_cnt;
    te0 = expired_cnt;
    applyStimulus("obs_block", 1'b0, 1'b0, 1'b1, P_OPEN, 1'b1, 1'b0);
    secTick(15);
    expectState("obs_held_15s", P_OPEN, 1'b0, 1'b0);
    checkCount("obs_no_expiry_held", expired_cnt - te0, 0);
    checkCount("obs_single_restart", restart_cnt - rs0, 1);
    applyStimulus("obs_release", 1'b0, 1'b0, 1'b0, P_OPEN, 1'b0, 1'b0);
    secTick(9);
    expectState("obs_9s_after_release", P_OPEN, 1'b0, 1'b0);
    checkCount("obs_no_expiry_9s", expired_cnt - te0, 0);
    secTick(1);
    expectState("obs_expired", P_CLOSING, 1'b0, 1'b0);
    checkCount("obs_expired_once", expired_cnt - te0, 1);

    // Reversal after 1 s of closing: reopens in 1 s.
    secTick(1);
    applyStimulus("rev_partial", 1'b0, 1'b0, 1'b1, P_OPENING, 1'b1, 1'b0);
    applyStimulus("rev_release", 1'b0, 1'b0, 1'b0, P_OPENING, 1'b0, 1'b0);
    secTick(1);
    expectState("rev_reopened", P_OPEN, 1'b0, 1'b0);

    // Reversal at cnt==0 goes straight back to ABIERTA with one restart.
    secTick(10);
    expectState("rev_closing_again", P_CLOSING, 1'b0, 1'b0);
    applyStimulus("rev_at_zero", 1'b0, 1'b0, 1'b1, P_OPEN, 1'b1, 1'b0);
    applyStimulus("rev_zero_no_second_restart", 1'b0, 1'b0, 1'b1, P_OPEN, 1'b0, 1'b0);

    // Obstruction beats closeReq; once cleared, closeReq closes early.
    applyStimulus("prio_both", 1'b0, 1'b1, 1'b1, P_OPEN, 1'b0, 1'b0);
    secTick(12);
    expectState("prio_held", P_OPEN, 1'b0, 1'b0);
    applyStimulus("prio_close_after_clear", 1'b0, 1'b1, 1'b0, P_CLOSING, 1'b1, 1'b0);
    applyStimulus("prio_close_release", 1'b0, 1'b0, 1'b0, P_CLOSING, 1'b0, 1'b0);

    // Tick coinciding with obstruction at cnt==1: reopen preloaded to 1.
    secTick(1);
    bus.C_1Hz = 1'b1;
    cyc(3);
    applyStimulus("tick_coincide_rev", 1'b0, 1'b0, 1'b1, P_OPENING, 1'b1, 1'b0);
    applyStimulus("tick_coincide_release", 1'b0, 1'b0, 1'b0, P_OPENING, 1'b0, 1'b0);
    bus.C_1Hz = 1'b0;
    cyc(4);
    expectState("tick_discarded", P_OPENING, 1'b0, 1'b0);
    secTick(1);
    expectState("tick_preload_reopen", P_OPEN, 1'b0, 1'b0);

    // Asynchronous reset in the middle of ABRIENDO.
    applyStimulus("ar_close", 1'b0, 1'b1, 1'b0, P_CLOSING, 1'b1, 1'b0);
    applyStimulus("ar_close_release", 1'b0, 1'b0, 1'b0, P_CLOSING, 1'b0, 1'b0);
    secTick(2);
    expectState("ar_closed", P_CLOSED, 1'b0, 1'b0);
    applyStimulus("ar_open", 1'b1, 1'b0, 1'b0, P_OPENING, 1'b1, 1'b0);
    cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    expectState("ar_async_reset", P_CLOSED, 1'b0, 1'b0);
    bus.openReq = 1'b0;
    @(negedge C_100Mhz);
    rst_n = 1'b1;
    cyc(2);
    secTick(2);
    expectState("ar_no_retained_request", P_CLOSED, 1'b0, 1'b0);

    checkCount("monitor_invariants", mon_errors, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
